// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
//   seg7_t       : segment vector {g,f,e,d,c,b,a}, active-high
//   HEX7         : hex font table, nibble 0..F -> seg7_t
//   DEF_*        : default refresh slot length and anti-ghost guard length
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam int DEF_REFRESH_CYCLES = 100_000;
   localparam int DEF_GUARD_CYCLES   = 16;

   localparam seg7_t HEX7 [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

endpackage

// File: rtl/bto7s.sv
// Binary nibble to seven-segment decoder (combinational, active-high).
//   bin_in  : 4-bit value
//   seg_out : segments {g,f,e,d,c,b,a}
module bto7s
   import seg7_pkg::*;
(
   input  logic [3:0] bin_in,
   output seg7_t      seg_out
);

   assign seg_out = HEX7[bin_in];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver sharing one cathode bus.
// Each digit owns one refresh slot of REFRESH_CYCLES clocks; the first
// GUARD_CYCLES of every slot keep all anodes off so the previous digit's
// segments cannot ghost onto the next one.
//   clk_in   : system clock
//   rst_in   : synchronous reset, active-high
//   val_in   : hex nibble per digit, digit i = val_in[4i+3:4i]
//   dp_in    : decimal point request per digit
//   blank_in : per-digit blank (anode never enabled)
//   load_in  : capture val_in/dp_in/blank_in into shadow registers
//   cat_out  : segments {g..a}, polarity per ACTIVE_LOW
//   dp_out   : decimal point segment, polarity per ACTIVE_LOW
//   an_out   : anode enables (one-hot or none), polarity per ACTIVE_LOW
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
   parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
   parameter bit ACTIVE_LOW     = 1'b1
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [4*NUM_DIGITS-1:0] val_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    load_in,
   output seg7_t                   cat_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out
);

   localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   // One bit wider than cnt so a guard equal to 2**CW still compares correctly.
   localparam logic [CW:0]   GUARD_W = (CW+1)'(GUARD_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   generate
      if (REFRESH_CYCLES <= GUARD_CYCLES) begin : g_bad_refresh
         $error("seg7_scan_driver: REFRESH_CYCLES must exceed GUARD_CYCLES");
      end
      if (NUM_DIGITS < 1) begin : g_bad_digits
         $error("seg7_scan_driver: NUM_DIGITS must be >= 1");
      end
   endgenerate

   logic [CW-1:0]                cnt;
   logic [IW-1:0]                idx;
   logic [NUM_DIGITS-1:0][3:0]   val_sh;
   logic [NUM_DIGITS-1:0]        dp_sh;
   logic [NUM_DIGITS-1:0]        blank_sh;

   logic [3:0]                   nib;
   seg7_t                        seg;
   logic                         guard;
   logic [NUM_DIGITS-1:0]        an_nxt;
   seg7_t                        cat_nxt;
   logic                         dp_nxt;

   // Output word for the current (cnt, idx); registered below so the pins
   // lag the counters by one cycle and never glitch.
   always_comb begin
      nib     = val_sh[idx];
      guard   = ({1'b0, cnt} < GUARD_W) || blank_sh[idx];
      an_nxt  = '0;
      cat_nxt = '0;
      dp_nxt  = 1'b0;
      if (!guard) begin
         an_nxt  = NUM_DIGITS'(1) << idx;
         cat_nxt = seg;
         dp_nxt  = dp_sh[idx];
      end
   end

   bto7s u_bto7s (
      .bin_in  (nib),
      .seg_out (seg)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt      <= '0;
         idx      <= '0;
         val_sh   <= '0;
         dp_sh    <= '0;
         blank_sh <= '1;
         an_out   <= {NUM_DIGITS{ACTIVE_LOW}};
         cat_out  <= {7{ACTIVE_LOW}};
         dp_out   <= ACTIVE_LOW;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // Mid-slot loads take effect on the next output register update;
         // the slot timing is deliberately left untouched.
         if (load_in) begin
            val_sh   <= val_in;
            dp_sh    <= dp_in;
            blank_sh <= blank_in;
         end

         an_out  <= an_nxt  ^ {NUM_DIGITS{ACTIVE_LOW}};
         cat_out <= cat_nxt ^ {7{ACTIVE_LOW}};
         dp_out  <= dp_nxt  ^ ACTIVE_LOW;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int RC = 8;
   localparam int GC = 2;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic [15:0]   val_in = '0;
   logic [3:0]    dp_in = '0;
   logic [3:0]    blank_in = '0;
   logic          load_in = 1'b0;
   logic [6:0]    cat_out;
   logic          dp_out;
   logic [3:0]    an_out;

   always #5 clk_in = ~clk_in;

   seg7_scan_driver #(
      .NUM_DIGITS     (ND),
      .REFRESH_CYCLES (RC),
      .GUARD_CYCLES   (GC),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .val_in   (val_in),
      .dp_in    (dp_in),
      .blank_in (blank_in),
      .load_in  (load_in),
      .cat_out  (cat_out),
      .dp_out   (dp_out),
      .an_out   (an_out)
   );

   typedef struct {
      logic [3:0] an;
      logic [6:0] cat;
      logic       dp;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int errors  = 0;

   // Reference model: edges since reset, plus the loaded display contents.
   int         n = 0;
   logic [3:0] m_val [ND];
   bit         m_dp [ND];
   bit         m_blank [ND];

   function automatic logic [6:0] font(input logic [3:0] h);
      case (h)
         4'h0: font = 7'h3F; 4'h1: font = 7'h06; 4'h2: font = 7'h5B; 4'h3: font = 7'h4F;
         4'h4: font = 7'h66; 4'h5: font = 7'h6D; 4'h6: font = 7'h7D; 4'h7: font = 7'h07;
         4'h8: font = 7'h7F; 4'h9: font = 7'h6F; 4'hA: font = 7'h77; 4'hB: font = 7'h7C;
         4'hC: font = 7'h39; 4'hD: font = 7'h5E; 4'hE: font = 7'h79; default: font = 7'h71;
      endcase
   endfunction

   // Drive one cycle of stimulus and queue what the pins must show after it.
   task automatic cyc(input bit rst, input bit load, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b);
      exp_t e;
      int   slot_pos, digit;
      @(negedge clk_in);
      rst_in   = rst;
      load_in  = load;
      val_in   = v;
      dp_in    = d;
      blank_in = b;
      if (rst) begin
         e.an = 4'hF; e.cat = 7'h7F; e.dp = 1'b1;
         n = 0;
         for (int i = 0; i < ND; i++) begin
            m_val[i] = 4'h0; m_dp[i] = 1'b0; m_blank[i] = 1'b1;
         end
      end else begin
         slot_pos = n % RC;
         digit    = (n / RC) % ND;
         if (slot_pos < GC || m_blank[digit]) begin
            e.an = 4'hF; e.cat = 7'h7F; e.dp = 1'b1;
         end else begin
            e.an  = ~(4'b0001 << digit);
            e.cat = ~font(m_val[digit]);
            e.dp  = ~m_dp[digit];
         end
         if (load) begin
            for (int i = 0; i < ND; i++) begin
               m_val[i]   = v[4*i +: 4];
               m_dp[i]    = d[i];
               m_blank[i] = b[i];
            end
         end
         n++;
      end
      q.push_back(e);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, $urandom, $urandom, $urandom);
   endtask

   // Monitor: every edge presents an output word; compare it to the queue head.
   always @(posedge clk_in) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         vectors++;
         if (an_out !== e.an || cat_out !== e.cat || dp_out !== e.dp) begin
            errors++;
            $display("FAIL pins @%0t: an/cat/dp got %h/%h/%b expected %h/%h/%b",
                     $time, an_out, cat_out, dp_out, e.an, e.cat, e.dp);
         end
         vectors++;
         if ($countones(~an_out) > 1) begin
            errors++;
            $display("FAIL onehot @%0t: an_out got %b expected at most one low", $time, an_out);
         end
         vectors++;
         if (an_out === 4'hF && (cat_out !== 7'h7F || dp_out !== 1'b1)) begin
            errors++;
            $display("FAIL dark_segs @%0t: cat/dp got %h/%b expected 7f/1", $time, cat_out, dp_out);
         end
      end
   end

   initial begin
      int guard_cnt;
      // Reset held 3 cycles; load during reset must be ignored.
      cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      cyc(1'b1, 1'b1, 16'hABCD, 4'hF, 4'h0);
      cyc(1'b1, 1'b1, 16'h1234, 4'hF, 4'h0);
      idle(10);                                     // still all blank

      // Plain scan of 0,1,2,3.
      cyc(1'b0, 1'b1, 16'h3210, 4'h0, 4'h0);
      idle(70);

      // Blank digit 2, dp on digit 0 only, all eights.
      cyc(1'b0, 1'b1, 16'h8888, 4'b0001, 4'b0100);
      idle(40);

      // Mid-slot load at digit1, cnt=4.
      guard_cnt = 0;
      while (!((n % RC) == 4 && ((n / RC) % ND) == 1) && guard_cnt < 64) begin
         cyc(1'b0, 1'b0, $urandom, $urandom, $urandom);
         guard_cnt++;
      end
      cyc(1'b0, 1'b1, 16'h00F0, 4'h0, 4'h0);
      idle(40);                                     // also: input churn without load

      // Reset mid-scan at digit3, cnt=5.
      guard_cnt = 0;
      while (!((n % RC) == 5 && ((n / RC) % ND) == 3) && guard_cnt < 64) begin
         cyc(1'b0, 1'b0, $urandom, $urandom, $urandom);
         guard_cnt++;
      end
      cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(40);
      cyc(1'b0, 1'b1, 16'hFEDC, 4'b1010, 4'b0000);
      idle(40);

      // Random traffic.
      for (int i = 0; i < 600; i++)
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
             $urandom, $urandom, $urandom);

      // Drain: final queued entries are popped within a couple of edges.
      repeat (3) @(negedge clk_in);
      vectors++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: queue depth got %0d expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
